// File: rtl/pc_gen_pkg.sv
// Shared constants for the instruction-fetch PC generator: address and stall
// bus widths, reset/chip-enable encodings, the default reset vector and the
// redirect alignment helper. Optional feature macro: PC_ALIGN_CHK_EN.
package pc_gen_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned STALL_W_DEF = 6;
    localparam int unsigned INC_DEF     = 4;

    localparam logic [INST_ADDR_W-1:0] RESET_VEC_DEF = 32'h0000_0000;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [STALL_W_DEF-1:0] stall_bus_t;

    // Fetch state; the encoding equals the chip-enable level.
    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } pc_state_e;

    // A redirect target is word-misaligned when either low address bit is set.
    function automatic logic misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer for a branch target that arrives while fetch is stalled.
// clear has priority over load so a flush in the same cycle always wins.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] target,
    output logic              pend,
    output logic [ADDR_W-1:0] pend_target
);

    logic              pend_r;
    logic [ADDR_W-1:0] pend_target_r;

    // Capture or drop the buffered redirect; reset never lets one survive.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pend_r        <= 1'b0;
            pend_target_r <= {ADDR_W{1'b0}};
        end else if (clear) begin
            pend_r        <= 1'b0;
        end else if (load) begin
            pend_r        <= 1'b1;
            pend_target_r <= target;
        end
    end

    assign pend        = pend_r;
    assign pend_target = pend_target_r;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for instruction fetch: stall hold, flush and
// branch redirects, buffered redirect during stall, chip enable.
// Optional feature macro: PC_ALIGN_CHK_EN (reject misaligned branch targets).
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned        ADDR_W    = INST_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(RESET_VEC_DEF),
    parameter int unsigned        INC       = INC_DEF,
    parameter int unsigned        STALL_W   = STALL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_pc,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pend,
    output logic               addr_err,
    output logic [ADDR_W-1:0]  bad_addr
);

    localparam logic [ADDR_W-1:0] INC_EXT = ADDR_W'(INC);

    pc_state_e         state_r;
    pc_state_e         state_next_s;
    logic              ce_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic              stalled_s;
    logic              pend_load_s;
    logic              pend_clear_s;
    logic              pend_s;
    logic [ADDR_W-1:0] pend_target_s;
`ifdef PC_ALIGN_CHK_EN
    logic              rej_s;
    logic [ADDR_W-1:0] rej_addr_s;
    logic              addr_err_r;
    logic [ADDR_W-1:0] bad_addr_r;
`endif

    assign pc_inc_s  = pc_r + INC_EXT;
    assign stalled_s = (stall != {STALL_W{1'b0}});

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (pend_load_s),
        .clear       (pend_clear_s),
        .target      (br_target),
        .pend        (pend_s),
        .pend_target (pend_target_s)
    );

    // State register: reset forces OFF, otherwise follow next-state logic.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_r <= ST_OFF;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: the first edge out of reset enables fetch, then it stays on.
    always_comb begin
        state_next_s = ST_OFF;
        case (state_r)
            ST_OFF:  state_next_s = ST_RUN;
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_OFF;
        endcase
    end

    // Output decode: chip enable follows the fetch state.
    always_comb begin
        ce_s = CHIP_DISABLE;
        case (state_r)
            ST_OFF:  ce_s = CHIP_DISABLE;
            ST_RUN:  ce_s = CHIP_ENABLE;
            default: ce_s = CHIP_DISABLE;
        endcase
    end

    // Priority redirect mux: flush, stall (with capture), branch, buffered, increment.
    always_comb begin
        pc_next_s    = pc_r;
        pend_load_s  = 1'b0;
        pend_clear_s = 1'b0;
`ifdef PC_ALIGN_CHK_EN
        rej_s        = 1'b0;
        rej_addr_s   = {ADDR_W{1'b0}};
`endif
        case (state_r)
            ST_OFF: begin
                pc_next_s = RESET_VEC;
            end
            ST_RUN: begin
                if (flush) begin
                    pc_next_s    = flush_pc;
                    pend_clear_s = 1'b1;
                end else if (stalled_s) begin
                    pc_next_s    = pc_r;
                    pend_load_s  = br_valid;
                end else if (br_valid) begin
                    pend_clear_s = 1'b1;
`ifdef PC_ALIGN_CHK_EN
                    if (misaligned(br_target[1:0])) begin
                        pc_next_s  = pc_inc_s;
                        rej_s      = 1'b1;
                        rej_addr_s = br_target;
                    end else begin
                        pc_next_s  = br_target;
                    end
`else
                    pc_next_s    = br_target;
`endif
                end else if (pend_s) begin
                    pend_clear_s = 1'b1;
`ifdef PC_ALIGN_CHK_EN
                    if (misaligned(pend_target_s[1:0])) begin
                        pc_next_s  = pc_inc_s;
                        rej_s      = 1'b1;
                        rej_addr_s = pend_target_s;
                    end else begin
                        pc_next_s  = pend_target_s;
                    end
`else
                    pc_next_s    = pend_target_s;
`endif
                end else begin
                    pc_next_s    = pc_inc_s;
                end
            end
            default: begin
                pc_next_s = RESET_VEC;
            end
        endcase
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_r <= RESET_VEC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    // Rejection report: one-cycle error pulse, offending address held until replaced.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            addr_err_r <= 1'b0;
            bad_addr_r <= {ADDR_W{1'b0}};
        end else begin
            addr_err_r <= rej_s;
            if (rej_s) begin
                bad_addr_r <= rej_addr_s;
            end
        end
    end

    assign addr_err = addr_err_r;
    assign bad_addr = bad_addr_r;
`else
    assign addr_err = 1'b0;
    assign bad_addr = {ADDR_W{1'b0}};
`endif

    assign pc            = pc_r;
    assign ce            = ce_s;
    assign redirect_pend = pend_s;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a behavioural model pushes the expected
// outputs for every driven cycle into a queue; they are popped and compared
// one time unit after the clock edge. Directed scenarios also compare against
// literal values from the intended behaviour.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        ce;
    logic        redirect_pend;
    logic        addr_err;
    logic [31:0] bad_addr;

    int total_cnt;
    int bad_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        err;
        logic [31:0] bad;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state.
    logic        m_ce;
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pt;
    logic        m_err;
    logic [31:0] m_bad;

`ifdef PC_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .br_valid      (br_valid),
        .br_target     (br_target),
        .pc            (pc),
        .ce            (ce),
        .redirect_pend (redirect_pend),
        .addr_err      (addr_err),
        .bad_addr      (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [31:0] tgt;
        if (rst) begin
            m_ce = 1'b0; m_pc = 32'h0; m_pend = 1'b0; m_pt = 32'h0;
            m_err = 1'b0; m_bad = 32'h0;
        end else if (!m_ce) begin
            m_ce  = 1'b1;
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (flush) begin
                m_pc   = flush_pc;
                m_pend = 1'b0;
            end else if (stall != 6'd0) begin
                if (br_valid) begin
                    m_pt   = br_target;
                    m_pend = 1'b1;
                end
            end else if (br_valid || m_pend) begin
                tgt    = br_valid ? br_target : m_pt;
                m_pend = 1'b0;
                if (ALIGN_CHK && (tgt[1:0] != 2'b00)) begin
                    m_pc  = m_pc + 32'd4;
                    m_err = 1'b1;
                    m_bad = tgt;
                end else begin
                    m_pc = tgt;
                end
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Drive one cycle of stimulus, push the expectation, then compare after the edge.
    task automatic cyc(input logic r, input logic [5:0] st, input logic fl,
                       input logic [31:0] fpc, input logic bv, input logic [31:0] bt);
        exp_t e;
        rst = r; stall = st; flush = fl; flush_pc = fpc; br_valid = bv; br_target = bt;
        model_step();
        exp_q.push_back('{pc: m_pc, ce: m_ce, pend: m_pend, err: m_err, bad: m_bad});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("sb_pc",   pc,                     e.pc);
            chk("sb_ce",   {31'd0, ce},            {31'd0, e.ce});
            chk("sb_pend", {31'd0, redirect_pend}, {31'd0, e.pend});
            chk("sb_err",  {31'd0, addr_err},      {31'd0, e.err});
            chk("sb_bad",  bad_addr,               e.bad);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst = 1'b1; stall = 6'd0; flush = 1'b0; flush_pc = 32'h0;
        br_valid = 1'b0; br_target = 32'h0;
        m_ce = 1'b0; m_pc = 32'h0; m_pend = 1'b0; m_pt = 32'h0;
        m_err = 1'b0; m_bad = 32'h0;

        // Reset for three cycles, then release.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("rst_ce", {31'd0, ce}, 32'd0);
            chk("rst_pc", pc, 32'h0);
        end
        idle();
        chk("rel_ce", {31'd0, ce}, 32'd1);
        chk("rel_pc", pc, 32'h0);
        idle(); chk("seq_4", pc, 32'h4);
        idle(); chk("seq_8", pc, 32'h8);
        idle(); chk("seq_c", pc, 32'hC);

        // Stall with a branch captured in the second stall cycle.
        cyc(1'b0, 6'b000100, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b0, 6'b000100, 1'b0, 32'h0, 1'b1, 32'h100);
        chk("stall_hold", pc, 32'hC);
        chk("stall_pend", {31'd0, redirect_pend}, 32'd1);
        cyc(1'b0, 6'b000100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall_hold2", pc, 32'hC);
        idle();
        chk("pend_pc", pc, 32'h100);
        chk("pend_clr", {31'd0, redirect_pend}, 32'd0);
        idle(); chk("pend_after", pc, 32'h104);

        // Flush beats stall and a buffered redirect.
        cyc(1'b0, 6'b100000, 1'b0, 32'h0, 1'b1, 32'h100);
        cyc(1'b0, 6'b100000, 1'b1, 32'hBFC0_0380, 1'b0, 32'h0);
        chk("flush_pc", pc, 32'hBFC0_0380);
        chk("flush_pend", {31'd0, redirect_pend}, 32'd0);
        idle(); chk("flush_seq", pc, 32'hBFC0_0384);

        // Wrap at the top of the address space.
        cyc(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        idle(); chk("wrap_top", pc, 32'hFFFF_FFFC);
        idle(); chk("wrap_zero", pc, 32'h0);

        // Reset while a redirect is buffered.
        cyc(1'b0, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h300);
        chk("mid_pend", {31'd0, redirect_pend}, 32'd1);
        cyc(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("mid_rst_pend", {31'd0, redirect_pend}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        idle(); chk("mid_rel_pc", pc, 32'h0);
        idle(); chk("mid_no_stale", pc, 32'h4);

        // Misaligned branch target at pc=0x40.
        cyc(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 32'h40);
        chk("al_at40", pc, 32'h40);
        cyc(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 32'h102);
        if (ALIGN_CHK) begin
            chk("al_pc", pc, 32'h44);
            chk("al_err", {31'd0, addr_err}, 32'd1);
            chk("al_bad", bad_addr, 32'h102);
        end else begin
            chk("al_pc", pc, 32'h102);
            chk("al_err", {31'd0, addr_err}, 32'd0);
        end
        idle();
        chk("al_err_pulse", {31'd0, addr_err}, 32'd0);

        // Misaligned target captured during stall, applied after release.
        cyc(1'b0, 6'b010000, 1'b0, 32'h0, 1'b1, 32'h206);
        idle();
        chk("alp_pc", pc, ALIGN_CHK ? m_pc : 32'h206);
        chk("alp_pend", {31'd0, redirect_pend}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [5:0]  st;
            logic        fl;
            logic        bv;
            logic [31:0] bt;
            r  = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            fl = ($urandom_range(0, 9) == 0);
            bv = ($urandom_range(0, 3) == 0);
            bt = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                bt[1:0] = 2'b00;
            end
            cyc(r, st, fl, {$urandom} & 32'hFFFF_FFFC, bv, bt);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the instruction-fetch stage: the second-generation PC register. It holds the fetch address and the instruction-memory chip enable. It adds pipeline stall, branch/jump redirect, exception flush redirect, and a one-entry buffer for redirects that arrive while the PC is stalled. It drives the instruction ROM/cache address and the IF/ID pipeline register.

## Interface
- ADDR_W, 32, PC / address width in bits
- RESET_VEC, 32'h0000_0000 (ADDR_W bits), first fetch address after reset
- INC, 4, sequential increment in bytes
- STALL_W, 6, width of the stall vector (one bit per stall source)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  STALL_W  PC hold request; any bit set holds PC
- flush  in  1  exception/ERET redirect, highest priority
- flush_pc  in  ADDR_W  flush target
- br_valid  in  1  branch/jump redirect request from ID
- br_target  in  ADDR_W  branch/jump target
- pc  out  ADDR_W  current fetch address
- ce  out  1  instruction-memory chip enable (ChipEnable/ChipDisable)
- redirect_pend  out  1  a branch target is buffered, awaiting stall release
- addr_err  out  1  misaligned redirect rejected (one-cycle pulse; see Configuration)
- bad_addr  out  ADDR_W  rejected target, held until next rejection or reset

## Operation
- Two-state FSM, encoded by ce:
  - OFF (ce=0): entered on any edge with rst=1.
  - RUN (ce=1): entered on the first edge with rst=0.
- Reset edge (rst=1, regardless of state) sets ce=0, pc=RESET_VEC, redirect_pend=0, pend_target=0, addr_err=0 and bad_addr=0.
- OFF: pc holds RESET_VEC. flush, br_valid and stall are ignored. The OFF→RUN edge leaves pc at RESET_VEC, so the first enabled fetch is RESET_VEC.
- RUN: each edge applies the first matching rule, in this priority order:
  1. flush=1: pc←flush_pc; redirect_pend←0. Applies even when stalled.
  2. stall≠0: pc holds. If br_valid=1, pend_target←br_target and redirect_pend←1. If several branches arrive during one stall, the last one wins.
  3. br_valid=1: pc←br_target; redirect_pend←0. A new branch supersedes the buffered one.
  4. redirect_pend=1: pc←pend_target; redirect_pend←0.
  5. otherwise: pc←pc+INC.
- Arithmetic: pc+INC is computed modulo 2^ADDR_W, so pc wraps silently from the top of the address space to 0. INC is zero-extended to ADDR_W.
- rst asserted mid-operation discards any buffered redirect; no redirect survives reset.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Redirect latency is 1 cycle: flush or br_valid sampled at edge N makes the target visible on pc after edge N.
- A buffered redirect appears on pc 1 cycle after the stall deasserts.
- ce rises 1 cycle after rst falls and falls 1 cycle after rst rises.
- addr_err is high for exactly the cycle following the rejecting edge.

## Configuration
- PC_ALIGN_CHK_EN defined:
  - A br_target or pend_target with any of bits [1:0] nonzero is not taken. pc←pc+INC instead, the pend entry is cleared, addr_err pulses, and bad_addr←offending target.
  - Capture of a misaligned target during stall is allowed; the check happens when the redirect is applied.
  - flush_pc is trusted and never checked.
- PC_ALIGN_CHK_EN undefined:
  - Targets are taken verbatim.
  - addr_err and bad_addr remain present, tied constant 0.

## Structure
- Shared constants go in the common macros include: InstAddrBus, RstEnable, ChipEnable/ChipDisable, plus a new StallBus and the default reset vector.
- One sub-module: pc_redirect_buf, holding the pend_target/redirect_pend register with load and clear inputs.
- Priority mux, increment and alignment check stay in pc_gen.

## Test plan
- Reset release: rst=1 for 3 cycles, then 0 → ce=0/pc=0 during reset; ce=1 with pc=0 on the first cycle after; pc=4, 8, C on the following cycles.
- Stall + buffered branch: stall=6'b000100 for 3 cycles, br_valid with target 0x100 in the 2nd stall cycle → pc held, redirect_pend=1; one cycle after stall drops, pc=0x100 and redirect_pend=0.
- Flush beats stall and pend: pend holds 0x100, stall≠0, flush with flush_pc=0xBFC00380 → pc=0xBFC00380 next cycle, redirect_pend=0.
- Wrap: pc=0xFFFFFFFC, no stall/redirect → pc=0x00000000.
- Reset mid-pend: redirect_pend=1, then rst for 1 cycle → redirect_pend=0, pc=RESET_VEC; no redirect to the stale target afterwards.
- With PC_ALIGN_CHK_EN: br_valid with target 0x102 at pc=0x40 → pc=0x44, addr_err=1 for one cycle, bad_addr=0x102. Without the macro: pc=0x102.
